// File: rtl/calc_inv_t_stream_pkg.sv
// Shared fixed-point defaults and saturation helper for the inverse-transmission engine.
package calc_inv_t_stream_pkg;

    localparam int unsigned F_DEF        = 12;
    localparam int unsigned K_INT_DEF    = 4;
    localparam int unsigned K_FRAC_DEF   = 8;
    localparam int unsigned RECIP_W_DEF  = 20;
    localparam int unsigned OUT_INT_DEF  = 4;
    localparam int unsigned OUT_FRAC_DEF = 8;
    localparam int unsigned DEN_MIN_DEF  = 1;
    localparam int unsigned SAT_W        = 64;

    typedef struct packed {
        logic             hit;
        logic [SAT_W-1:0] val;
    } sat_res_t;

    // Unsigned clamp to a ceiling; hit flags that the ceiling was applied.
    function automatic sat_res_t sat_min(input logic [SAT_W-1:0] v, input logic [SAT_W-1:0] lim);
        sat_res_t r;
        r.hit = (v > lim);
        r.val = r.hit ? lim : v;
        return r;
    endfunction

endpackage

// File: rtl/calc_inv_t_stream_if.sv
// Valid/ready stream bundle: statistics and per-beat config in, inv_t and saturation flag out.
interface calc_inv_t_stream_if
    import calc_inv_t_stream_pkg::*;
#(
    parameter int unsigned F  = F_DEF,
    parameter int unsigned KW = K_INT_DEF + K_FRAC_DEF,
    parameter int unsigned OW = OUT_INT_DEF + OUT_FRAC_DEF
);
    logic          in_valid;
    logic          in_ready;
    logic [F-1:0]  S_H;
    logic [F-1:0]  S_D;
    logic [KW-1:0] K;
    logic          cfg_bypass;
    logic [OW-1:0] cfg_inv_t_max;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] inv_t;
    logic          out_sat;

    modport master (
        output in_valid, S_H, S_D, K, cfg_bypass, cfg_inv_t_max, out_ready,
        input  in_ready, out_valid, inv_t, out_sat
    );

    modport slave (
        input  in_valid, S_H, S_D, K, cfg_bypass, cfg_inv_t_max, out_ready,
        output in_ready, out_valid, inv_t, out_sat
    );
endinterface

// File: rtl/calc_inv_t_stream_recip_rom.sv
// Synchronous reciprocal ROM: recip = min(floor(2^(2F)/addr), 2^RECIP_W-1), one-cycle read, held when !en.
module recip_rom
    import calc_inv_t_stream_pkg::*;
#(
    parameter int unsigned F       = F_DEF,
    parameter int unsigned RECIP_W = RECIP_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [F-1:0]       addr,
    output logic [RECIP_W-1:0] recip,
    output logic               clamp
);
    localparam int unsigned DEPTH = 1 << F;

    // Address 0 never occurs behind the denominator clamp; it is filled with the clamped maximum.
    function automatic logic [RECIP_W:0] entry(input int a);
        logic [63:0] lim;
        logic [63:0] full;
        lim  = (64'(1) << RECIP_W) - 64'(1);
        full = (a == 0) ? lim + 64'(1) : (64'(1) << (2 * F)) / 64'(a);
        if (full > lim) return {1'b1, RECIP_W'(lim)};
        else            return {1'b0, RECIP_W'(full)};
    endfunction

    logic [RECIP_W:0] rom [DEPTH];

    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        localparam logic [RECIP_W:0] ENTRY = entry(a);
        assign rom[a] = ENTRY;
    end

    logic [RECIP_W:0] word_d;
    logic [RECIP_W:0] word_q;

    always_comb begin
        word_d = word_q;
        if (en) word_d = rom[addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_q <= '0;
        else        word_q <= word_d;
    end

    assign recip = word_q[RECIP_W-1:0];
    assign clamp = word_q[RECIP_W];

endmodule

// File: rtl/calc_inv_t_stream.sv
// Five-stage streaming inv_t = S_D / (S_D - K*(S_D - S_H)) with ceiling, bypass and saturation flag.
module calc_inv_t_stream
    import calc_inv_t_stream_pkg::*;
#(
    parameter int unsigned F        = F_DEF,
    parameter int unsigned K_INT    = K_INT_DEF,
    parameter int unsigned K_FRAC   = K_FRAC_DEF,
    parameter int unsigned RECIP_W  = RECIP_W_DEF,
    parameter int unsigned OUT_INT  = OUT_INT_DEF,
    parameter int unsigned OUT_FRAC = OUT_FRAC_DEF,
    parameter int unsigned DEN_MIN  = DEN_MIN_DEF
) (
    input logic                clk,
    input logic                rst_n,
    calc_inv_t_stream_if.slave bus
);
    localparam int unsigned KW    = K_INT + K_FRAC;
    localparam int unsigned OW    = OUT_INT + OUT_FRAC;
    localparam int unsigned PW    = KW + F;
    localparam int unsigned QW    = F + RECIP_W;
    localparam int unsigned SHIFT = 2 * F - OUT_FRAC;

    logic adv;

    logic v1_d, v1_q, byp1_d, byp1_q;
    logic [F-1:0]  diff1_d, diff1_q, sd1_d, sd1_q;
    logic [KW-1:0] k1_d, k1_q;
    logic [OW-1:0] max1_d, max1_q;

    logic v2_d, v2_q, byp2_d, byp2_q, sat2_d, sat2_q;
    logic [F-1:0]  p2_d, p2_q, sd2_d, sd2_q;
    logic [OW-1:0] max2_d, max2_q;

    logic v3_d, v3_q, byp3_d, byp3_q, sat3_d, sat3_q;
    logic [F-1:0]  den3_d, den3_q, sd3_d, sd3_q;
    logic [OW-1:0] max3_d, max3_q;

    logic v4_d, v4_q, byp4_d, byp4_q, sat4_d, sat4_q;
    logic [F-1:0]  sd4_d, sd4_q;
    logic [OW-1:0] max4_d, max4_q;

    logic out_valid_d, out_valid_q, out_sat_d, out_sat_q;
    logic [OW-1:0] inv_t_d, inv_t_q;

    logic [RECIP_W-1:0] recip4;
    logic               rom_clamp;

    logic [F-1:0]  diff_c;
    logic [PW-1:0] pprod_c;
    sat_res_t      psat_c;
    logic [F-1:0]  den_raw_c;
    logic          den_hit_c;
    logic [QW-1:0] qprod_c;
    sat_res_t      qsat_c;
    logic [OW-1:0] inv_c;
    logic          osat_c;

    // Stage 4: reciprocal lookup, addressed by the registered denominator.
    recip_rom #(.F(F), .RECIP_W(RECIP_W)) u_recip_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .addr  (den3_q),
        .recip (recip4),
        .clamp (rom_clamp)
    );

    always_comb begin
        adv = ~out_valid_q | bus.out_ready;

        diff_c    = (bus.S_D >= bus.S_H) ? bus.S_D - bus.S_H : '0;
        pprod_c   = PW'(k1_q) * PW'(diff1_q);
        psat_c    = sat_min(SAT_W'(pprod_c >> K_FRAC), (SAT_W'(1) << F) - SAT_W'(1));
        den_raw_c = (sd2_q >= p2_q) ? sd2_q - p2_q : '0;
        den_hit_c = (den_raw_c < F'(DEN_MIN));
        qprod_c   = QW'(sd4_q) * QW'(recip4);
        qsat_c    = sat_min(SAT_W'(qprod_c >> SHIFT), SAT_W'(max4_q));
        inv_c     = byp4_q ? (OW'(1) << OUT_FRAC) : OW'(qsat_c.val);
        osat_c    = byp4_q ? 1'b0 : (sat4_q | rom_clamp | qsat_c.hit);

        v1_d = v1_q; byp1_d = byp1_q; diff1_d = diff1_q; sd1_d = sd1_q; k1_d = k1_q; max1_d = max1_q;
        v2_d = v2_q; byp2_d = byp2_q; sat2_d = sat2_q; p2_d = p2_q; sd2_d = sd2_q; max2_d = max2_q;
        v3_d = v3_q; byp3_d = byp3_q; sat3_d = sat3_q; den3_d = den3_q; sd3_d = sd3_q; max3_d = max3_q;
        v4_d = v4_q; byp4_d = byp4_q; sat4_d = sat4_q; sd4_d = sd4_q; max4_d = max4_q;
        out_valid_d = out_valid_q; inv_t_d = inv_t_q; out_sat_d = out_sat_q;

        // Whole pipe moves in lockstep so a stall never drops or duplicates a beat.
        if (adv) begin
            v1_d = bus.in_valid; byp1_d = bus.cfg_bypass; max1_d = bus.cfg_inv_t_max;
            diff1_d = diff_c; sd1_d = bus.S_D; k1_d = bus.K;

            v2_d = v1_q; byp2_d = byp1_q; max2_d = max1_q; sd2_d = sd1_q;
            p2_d = F'(psat_c.val); sat2_d = psat_c.hit;

            v3_d = v2_q; byp3_d = byp2_q; max3_d = max2_q; sd3_d = sd2_q;
            den3_d = den_hit_c ? F'(DEN_MIN) : den_raw_c; sat3_d = sat2_q | den_hit_c;

            v4_d = v3_q; byp4_d = byp3_q; max4_d = max3_q; sd4_d = sd3_q; sat4_d = sat3_q;

            out_valid_d = v4_q; inv_t_d = inv_c; out_sat_d = osat_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; byp1_q <= 1'b0; diff1_q <= '0; sd1_q <= '0; k1_q <= '0; max1_q <= '0;
            v2_q <= 1'b0; byp2_q <= 1'b0; sat2_q <= 1'b0; p2_q <= '0; sd2_q <= '0; max2_q <= '0;
            v3_q <= 1'b0; byp3_q <= 1'b0; sat3_q <= 1'b0; den3_q <= '0; sd3_q <= '0; max3_q <= '0;
            v4_q <= 1'b0; byp4_q <= 1'b0; sat4_q <= 1'b0; sd4_q <= '0; max4_q <= '0;
            out_valid_q <= 1'b0; inv_t_q <= '0; out_sat_q <= 1'b0;
        end else begin
            v1_q <= v1_d; byp1_q <= byp1_d; diff1_q <= diff1_d; sd1_q <= sd1_d; k1_q <= k1_d; max1_q <= max1_d;
            v2_q <= v2_d; byp2_q <= byp2_d; sat2_q <= sat2_d; p2_q <= p2_d; sd2_q <= sd2_d; max2_q <= max2_d;
            v3_q <= v3_d; byp3_q <= byp3_d; sat3_q <= sat3_d; den3_q <= den3_d; sd3_q <= sd3_d; max3_q <= max3_d;
            v4_q <= v4_d; byp4_q <= byp4_d; sat4_q <= sat4_d; sd4_q <= sd4_d; max4_q <= max4_d;
            out_valid_q <= out_valid_d; inv_t_q <= inv_t_d; out_sat_q <= out_sat_d;
        end
    end

    // in_ready follows out_ready combinationally and is forced low during reset.
    assign bus.in_ready  = rst_n & adv;
    assign bus.out_valid = out_valid_q;
    assign bus.inv_t     = inv_t_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_calc_inv_t_stream.sv
// Directed and backpressure bench for calc_inv_t_stream with a scoreboard of expected beats.
module tb_calc_inv_t_stream;
    import calc_inv_t_stream_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    calc_inv_t_stream_if bus ();

    calc_inv_t_stream dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [11:0] inv;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    bit          chk_lat = 1'b0;
    bit          hold_v  = 1'b0;
    logic [11:0] hold_inv;
    logic        hold_sat;
    logic [12:0] m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: fixed-point formula evaluated at full precision.
    function automatic logic [12:0] model(input logic [11:0] sh, input logic [11:0] sd,
                                          input logic [11:0] k, input logic byp, input logic [11:0] mx);
        longint unsigned diff, p, den, r, q, sdl;
        logic sat;
        sat  = 1'b0;
        sdl  = longint'(sd);
        diff = (sd >= sh) ? sdl - longint'(sh) : 0;
        p    = (longint'(k) * diff) >> 8;
        if (p > 4095) begin p = 4095; sat = 1'b1; end
        den  = (sdl >= p) ? sdl - p : 0;
        if (den < 1) begin den = 1; sat = 1'b1; end
        r    = (64'd1 << 24) / den;
        if (r > 1048575) begin r = 1048575; sat = 1'b1; end
        q    = (sdl * r) >> 16;
        if (q > longint'(mx)) begin q = longint'(mx); sat = 1'b1; end
        if (byp) begin q = 256; sat = 1'b0; end
        return {sat, q[11:0]};
    endfunction

    task automatic step(input logic iv, input logic [11:0] sh, input logic [11:0] sd, input logic [11:0] k,
                        input logic byp, input logic [11:0] mx, input logic [11:0] ei, input logic es,
                        input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        cyc++;
        if (hold_v) begin
            check("hold_out_valid", 32'(bus.out_valid), 1);
            check("hold_inv_t", 32'(bus.inv_t), 32'(hold_inv));
            check("hold_out_sat", 32'(bus.out_sat), 32'(hold_sat));
        end
        bus.in_valid = iv; bus.S_H = sh; bus.S_D = sd; bus.K = k;
        bus.cfg_bypass = byp; bus.cfg_inv_t_max = mx; bus.out_ready = ordy;
        #1;
        acc = iv & bus.in_ready;
        if (bus.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(bus.out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("inv_t", 32'(bus.inv_t), 32'(e.inv));
                check("out_sat", 32'(bus.out_sat), 32'(e.sat));
                if (chk_lat) check("latency", 32'(cyc - e.cyc), 5);
            end
        end
        hold_v   = bus.out_valid & ~ordy;
        hold_inv = bus.inv_t;
        hold_sat = bus.out_sat;
        if (acc) exp_q.push_back('{ei, es, cyc});
    endtask

    task automatic send(input logic [11:0] sh, input logic [11:0] sd, input logic [11:0] k, input logic byp,
                        input logic [11:0] mx, input logic [11:0] ei, input logic es, input bit rnd);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            step(1'b1, sh, sd, k, byp, mx, ei, es, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
            tries++;
        end
        if (!acc) check("accept_timeout", 32'(acc), 1);
    endtask

    task automatic drain(input bit rnd);
        logic acc;
        int   budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 80) begin
            step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
            budget++;
        end
        check("drain_empty", 32'(exp_q.size()), 0);
        repeat (3) step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.S_H = '0; bus.S_D = '0; bus.K = '0;
        bus.cfg_bypass = 1'b0; bus.cfg_inv_t_max = '0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 0);
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_inv_t", 32'(bus.inv_t), 0);
        check("reset_out_sat", 32'(bus.out_sat), 0);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 32'(bus.in_ready), 1);

        // Directed vectors, back to back with out_ready high.
        chk_lat = 1'b1;
        send(12'd1024, 12'd2048, 12'd256,  1'b0, 12'd4095, 12'd512,  1'b0, 1'b0); // nominal 2.0
        send(12'd3000, 12'd2048, 12'd256,  1'b0, 12'd4095, 12'd256,  1'b0, 1'b0); // S_H > S_D
        send(12'd0,    12'd4095, 12'd4095, 1'b0, 12'd2560, 12'd2560, 1'b1, 1'b0); // full saturation
        send(12'd0,    12'd4095, 12'd4095, 1'b1, 12'd2560, 12'd256,  1'b0, 1'b0); // bypass hides sat
        send(12'd50,   12'd100,  12'd300,  1'b0, 12'd4095, 12'd609,  1'b0, 1'b0); // after bypass
        send(12'd1024, 12'd2048, 12'd256,  1'b0, 12'd300,  12'd300,  1'b1, 1'b0); // ceiling hit
        send(12'd1024, 12'd2048, 12'd256,  1'b0, 12'd512,  12'd512,  1'b0, 1'b0); // equals ceiling
        send(12'd0,    12'd2048, 12'd128,  1'b0, 12'd4095, 12'd512,  1'b0, 1'b0); // K = 0.5
        send(12'd17,   12'd17,   12'd0,    1'b0, 12'd4095, 12'd255,  1'b0, 1'b0); // recip unclamped
        send(12'd16,   12'd16,   12'd0,    1'b0, 12'd4095, 12'd255,  1'b1, 1'b0); // recip clamped
        send(12'd0,    12'd0,    12'd0,    1'b0, 12'd4095, 12'd0,    1'b1, 1'b0); // zero numerator
        send(12'd1,    12'd1,    12'd0,    1'b0, 12'd4095, 12'd15,   1'b1, 1'b0); // den at DEN_MIN
        drain(1'b0);

        // Random beats under 50% backpressure.
        chk_lat = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [11:0] sh, sd, k, mx;
            logic        byp;
            sh  = 12'($urandom_range(0, 4095));
            sd  = 12'($urandom_range(0, 4095));
            k   = 12'($urandom_range(0, 767));
            mx  = 12'($urandom_range(0, 4095));
            byp = ($urandom_range(0, 7) == 0);
            m   = model(sh, sd, k, byp, mx);
            send(sh, sd, k, byp, mx, m[11:0], m[12], 1'b1);
        end
        drain(1'b1);

        // Reset with three beats in flight.
        send(12'd1024, 12'd2048, 12'd256, 1'b0, 12'd4095, 12'd512, 1'b0, 1'b0);
        send(12'd3000, 12'd2048, 12'd256, 1'b0, 12'd4095, 12'd256, 1'b0, 1'b0);
        send(12'd0,    12'd4095, 12'd4095, 1'b0, 12'd2560, 12'd2560, 1'b1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", 32'(bus.out_valid), 0);
        check("mid_reset_in_ready", 32'(bus.in_ready), 0);
        exp_q.delete();
        hold_v = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        check("no_stale_out_valid", 32'(bus.out_valid), 0);

        chk_lat = 1'b1;
        send(12'd1024, 12'd2048, 12'd256, 1'b0, 12'd4095, 12'd512, 1'b0, 1'b0);
        drain(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
